// File: rtl/hamming_ecc_sched_pkg.sv
// Shared types, widths and the round-robin helper for the hamming_ecc request scheduler.
package hamming_ecc_sched_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      QUIET
   } drain_state_e;

   localparam int unsigned QCNT_W = 4;
   localparam int unsigned STAT_W = 16;
   localparam int unsigned RR_MAX = 8;

   // Returns {any, index} of the first set request strictly after ptr, wrapping at nreq.
   function automatic logic [3:0] f_rr_next(input logic [RR_MAX-1:0] req,
                                            input logic [2:0]        ptr,
                                            input int unsigned       nreq);
      logic [3:0]  res;
      int unsigned idx;
      res = '0;
      for (int unsigned i = 1; i <= RR_MAX; i++) begin
         if (i <= nreq) begin
            idx = (32'(ptr) + i) % nreq;
            if (!res[3] && req[idx[2:0]]) begin
               res = {1'b1, idx[2:0]};
            end
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/hamming_ecc_sched_if.sv
// Write-request, FIFO-side and output-stream signals of hamming_ecc_sched.
interface hamming_ecc_sched_if #(
   parameter int unsigned DW   = 512,
   parameter int unsigned NREQ = 4
);
   logic [NREQ-1:0]    i_wr_valid;
   logic [NREQ*DW-1:0] i_wr_data;
   logic [NREQ-1:0]    o_wr_ready;
   logic               o_fifo_wreq;
   logic [DW-1:0]      o_fifo_wdata;
   logic               o_fifo_rreq;
   logic [DW-1:0]      i_fifo_rdata;
   logic               i_fifo_empty;
   logic               i_fifo_full;
   logic               o_rd_valid;
   logic [DW-1:0]      o_rd_data;
   logic               i_rd_ready;
   logic               o_drain_done;

   modport master (
      input  i_wr_valid, i_wr_data, i_fifo_rdata, i_fifo_empty, i_fifo_full, i_rd_ready,
      output o_wr_ready, o_fifo_wreq, o_fifo_wdata, o_fifo_rreq, o_rd_valid, o_rd_data,
             o_drain_done
   );

   modport slave (
      output i_wr_valid, i_wr_data, i_fifo_rdata, i_fifo_empty, i_fifo_full, i_rd_ready,
      input  o_wr_ready, o_fifo_wreq, o_fifo_wdata, o_fifo_rreq, o_rd_valid, o_rd_data,
             o_drain_done
   );
endinterface

// File: rtl/hamming_ecc_rr_arb.sv
// Round-robin arbiter: one-hot grant among req, pointer moves to the granted index on adv.
module hamming_ecc_rr_arb
   import hamming_ecc_sched_pkg::*;
#(
   parameter int unsigned NREQ = 4
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [NREQ-1:0] req,
   input  logic            adv,
   output logic [NREQ-1:0] gnt,
   output logic [2:0]      ptr
);

   logic [RR_MAX-1:0] req_pad;
   logic [3:0]        nxt;

   always_comb begin
      req_pad            = '0;
      req_pad[NREQ-1:0]  = req;
   end

   assign nxt = f_rr_next(req_pad, ptr, NREQ);

   always_comb begin
      gnt = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (nxt[3] && (nxt[2:0] == 3'(k))) begin
            gnt[k] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr <= 3'(NREQ - 1);
      end else if (adv && nxt[3]) begin
         ptr <= nxt[2:0];
      end
   end

endmodule

// File: rtl/hamming_ecc_sched.sv
// Shares one hamming_ecc FIFO between NREQ writers and one valid/ready reader.
// Optional per-requester grant statistics: define HAMMING_ECC_SCHED_STAT_EN.
module hamming_ecc_sched
   import hamming_ecc_sched_pkg::*;
#(
   parameter int unsigned DW        = 512,
   parameter int unsigned NREQ      = 4,
   parameter int unsigned RD_LAT    = 1,
   parameter int unsigned QUIET_CYC = 3
) (
   input  logic                     clk,
   input  logic                     reset_n,
   hamming_ecc_sched_if.master      bus
`ifdef HAMMING_ECC_SCHED_STAT_EN
   ,
   output logic [NREQ*STAT_W-1:0]   o_grant_cnt
`endif
);

   localparam int unsigned DEPTH = RD_LAT + 1;
   localparam int unsigned CW    = $clog2(DEPTH + 1);
   localparam int unsigned PW    = $clog2(DEPTH);

   // ---------------- write side ----------------
   logic [NREQ-1:0] arb_req;
   logic [NREQ-1:0] gnt;
   logic [2:0]      rr_ptr;
   logic            wr_xfer;
   logic [DW-1:0]   wr_sel;
   logic            wreq_q;
   logic [DW-1:0]   wdata_q;

   assign arb_req = bus.i_wr_valid & {NREQ{~bus.i_fifo_full & reset_n}};
   assign wr_xfer = |gnt;

   hamming_ecc_rr_arb #(.NREQ(NREQ)) u_arb (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (arb_req),
      .adv     (wr_xfer),
      .gnt     (gnt),
      .ptr     (rr_ptr)
   );

   always_comb begin
      wr_sel = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (gnt[k]) begin
            wr_sel = bus.i_wr_data[k*DW +: DW];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wreq_q  <= 1'b0;
         wdata_q <= '0;
      end else begin
         wreq_q <= wr_xfer;
         if (wr_xfer) begin
            wdata_q <= wr_sel;
         end
      end
   end

   assign bus.o_wr_ready   = gnt;
   assign bus.o_fifo_wreq  = wreq_q;
   assign bus.o_fifo_wdata = wdata_q;

   // ---------------- read side ----------------
   logic [CW-1:0]     credits;
   logic [CW-1:0]     buf_cnt;
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [DW-1:0]     buf_mem [DEPTH];
   logic [RD_LAT-1:0] inflight;
   logic              rreq;
   logic              pop;
   logic              cap;

   assign pop  = (buf_cnt != '0) & bus.i_rd_ready;
   // A pop in this cycle returns its slot, so it may fund a read in the same cycle.
   assign rreq = reset_n & ~bus.i_fifo_empty & ((credits != '0) | pop);
   assign cap  = inflight[RD_LAT-1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         inflight <= '0;
         credits  <= CW'(DEPTH);
         buf_cnt  <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
      end else begin
         inflight <= RD_LAT'({inflight, rreq});
         credits  <= credits - CW'(rreq) + CW'(pop);
         buf_cnt  <= buf_cnt + CW'(cap) - CW'(pop);
         if (cap) begin
            wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (cap) begin
         buf_mem[wr_ptr] <= bus.i_fifo_rdata;
      end
   end

   assign bus.o_fifo_rreq = rreq;
   assign bus.o_rd_valid  = (buf_cnt != '0);
   assign bus.o_rd_data   = (buf_cnt != '0) ? buf_mem[rd_ptr] : '0;

   // ---------------- drain tracking ----------------
   drain_state_e      state, state_nxt;
   logic [QCNT_W-1:0] qcnt, qcnt_nxt;
   logic              quiet;
   logic              drain_done;

   assign quiet = ~rreq & (inflight == '0) & (buf_cnt == '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         qcnt  <= '0;
      end else begin
         state <= state_nxt;
         qcnt  <= qcnt_nxt;
      end
   end

   // The current idle cycle is counted, so the pulse lands QUIET_CYC cycles after the last pop.
   always_comb begin
      state_nxt  = state;
      qcnt_nxt   = qcnt;
      drain_done = 1'b0;
      unique case (state)
         IDLE: begin
            if (rreq) begin
               state_nxt = BUSY;
               qcnt_nxt  = '0;
            end
         end
         BUSY, QUIET: begin
            if (rreq) begin
               state_nxt = BUSY;
               qcnt_nxt  = '0;
            end else if (quiet) begin
               if ((qcnt + QCNT_W'(1)) == QCNT_W'(QUIET_CYC)) begin
                  drain_done = 1'b1;
                  state_nxt  = IDLE;
                  qcnt_nxt   = '0;
               end else begin
                  state_nxt = QUIET;
                  qcnt_nxt  = qcnt + QCNT_W'(1);
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            qcnt_nxt  = '0;
         end
      endcase
   end

   assign bus.o_drain_done = drain_done;

`ifdef HAMMING_ECC_SCHED_STAT_EN
   logic [STAT_W-1:0] gcnt [NREQ];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned k = 0; k < NREQ; k++) gcnt[k] <= '0;
      end else if (drain_done) begin
         for (int unsigned k = 0; k < NREQ; k++) gcnt[k] <= '0;
      end else begin
         for (int unsigned k = 0; k < NREQ; k++) begin
            if (gnt[k] && (gcnt[k] != '1)) begin
               gcnt[k] <= gcnt[k] + STAT_W'(1);
            end
         end
      end
   end

   always_comb begin
      o_grant_cnt = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         o_grant_cnt[k*STAT_W +: STAT_W] = gcnt[k];
      end
   end
`endif

   a_grant_sane: assert property (@(posedge clk) disable iff (!reset_n)
      $onehot0(gnt) && (rr_ptr < 3'(NREQ)));
   a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
      !(cap && !pop && (buf_cnt == CW'(DEPTH))));

endmodule

// File: tb/tb_hamming_ecc_sched.sv
// Directed self-checking bench for hamming_ecc_sched with a small stand-in FIFO on the read side.
module tb_hamming_ecc_sched;

   localparam int unsigned DW        = 32;
   localparam int unsigned NREQ      = 4;
   localparam int unsigned RD_LAT    = 1;
   localparam int unsigned QUIET_CYC = 3;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   hamming_ecc_sched_if #(.DW(DW), .NREQ(NREQ)) bus ();

`ifdef HAMMING_ECC_SCHED_STAT_EN
   logic [NREQ*16-1:0] grant_cnt;
`endif

   hamming_ecc_sched #(
      .DW        (DW),
      .NREQ      (NREQ),
      .RD_LAT    (RD_LAT),
      .QUIET_CYC (QUIET_CYC)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
`ifdef HAMMING_ECC_SCHED_STAT_EN
      ,
      .o_grant_cnt (grant_cnt)
`endif
   );

   // stand-in for the hamming_ecc read port: one-cycle read latency
   logic [DW-1:0] fmem [32];
   int unsigned   fhead = 0;
   int unsigned   ftail = 0;

   assign bus.i_fifo_empty = (fhead == ftail);

   always @(posedge clk) begin
      if (bus.o_fifo_rreq && (fhead != ftail)) begin
         bus.i_fifo_rdata <= fmem[fhead % 32];
         fhead            <= fhead + 1;
      end
   end

   int unsigned total = 0;
   int unsigned bad   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [DW-1:0] w);
      fmem[ftail % 32] = w;
      ftail++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_ready"}, 64'(bus.o_wr_ready), 64'h0);
      check_eq({tag, "_wreq"},  64'(bus.o_fifo_wreq), 64'h0);
      check_eq({tag, "_wdata"}, 64'(bus.o_fifo_wdata), 64'h0);
      check_eq({tag, "_rreq"},  64'(bus.o_fifo_rreq), 64'h0);
      check_eq({tag, "_valid"}, 64'(bus.o_rd_valid), 64'h0);
      check_eq({tag, "_rdata"}, 64'(bus.o_rd_data), 64'h0);
      check_eq({tag, "_done"},  64'(bus.o_drain_done), 64'h0);
   endtask

   int unsigned gseq [4] = '{0, 2, 0, 2};
   int unsigned n_rreq;
   int unsigned n_pop;
   int unsigned n_done;

   initial begin
      bus.i_wr_valid  = '0;
      bus.i_wr_data   = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
      bus.i_fifo_full = 1'b0;
      bus.i_rd_ready  = 1'b1;

      // reset state, with every requester asking
      tick();
      bus.i_wr_valid = 4'b1111;
      @(negedge clk);
      check_all_zero("rst");
      tick();
      bus.i_wr_valid = '0;
      reset_n        = 1'b1;

      // requesters 0 and 2: grants alternate, wreq follows one cycle later
      tick();
      bus.i_wr_valid = 4'b0101;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_eq("rr_grant", 64'(bus.o_wr_ready), 64'(4'(1 << gseq[i])));
         check_eq("rr_wreq", 64'(bus.o_fifo_wreq), (i > 0) ? 64'h1 : 64'h0);
         if (i > 0) check_eq("rr_wdata", 64'(bus.o_fifo_wdata), 64'(32'hA000_0000 + gseq[i-1]));
         tick();
      end

      // full blocks every grant; after release the pointer resumes after 2
      bus.i_fifo_full = 1'b1;
      bus.i_wr_valid  = 4'b1111;
      @(negedge clk);
      check_eq("full_ready0", 64'(bus.o_wr_ready), 64'h0);
      check_eq("full_wreq_last", 64'(bus.o_fifo_wreq), 64'h1);
      check_eq("full_wdata_last", 64'(bus.o_fifo_wdata), 64'hA000_0002);
      tick();
      @(negedge clk);
      check_eq("full_ready1", 64'(bus.o_wr_ready), 64'h0);
      check_eq("full_wreq", 64'(bus.o_fifo_wreq), 64'h0);
      tick();
      bus.i_fifo_full = 1'b0;
      @(negedge clk);
      check_eq("unfull_grant", 64'(bus.o_wr_ready), 64'h8);
      tick();
      @(negedge clk);
      check_eq("unfull_wreq", 64'(bus.o_fifo_wreq), 64'h1);
      check_eq("unfull_wdata", 64'(bus.o_fifo_wdata), 64'hA000_0003);
      check_eq("wrap_grant", 64'(bus.o_wr_ready), 64'h1);
      tick();
      bus.i_wr_valid = '0;

      // 4-word burst, consumer always ready
      for (int n = 0; n < 4; n++) push(32'hD000_0000 + 32'(n));
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check_eq("burst_rreq", 64'(bus.o_fifo_rreq), (i <= 3) ? 64'h1 : 64'h0);
         check_eq("burst_valid", 64'(bus.o_rd_valid), (i >= 2 && i <= 5) ? 64'h1 : 64'h0);
         if (i >= 2 && i <= 5) check_eq("burst_data", 64'(bus.o_rd_data), 64'(32'hD000_0000 + 32'(i - 2)));
         check_eq("burst_done", 64'(bus.o_drain_done), (i == 8) ? 64'h1 : 64'h0);
         tick();
      end

      // consumer stalled: only buffer-depth reads go out
      bus.i_rd_ready = 1'b0;
      for (int n = 0; n < 5; n++) push(32'hE000_0000 + 32'(n));
      n_rreq = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus.o_fifo_rreq) n_rreq++;
         tick();
      end
      check_eq("stall_rreq_cnt", 64'(n_rreq), 64'd2);
      check_eq("stall_valid", 64'(bus.o_rd_valid), 64'h1);
      check_eq("stall_head", 64'(bus.o_rd_data), 64'hE000_0000);
      bus.i_rd_ready = 1'b1;
      n_pop  = 0;
      n_done = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.o_fifo_rreq) n_rreq++;
         if (bus.o_drain_done) n_done++;
         if (bus.o_rd_valid && bus.i_rd_ready) begin
            check_eq("stream_data", 64'(bus.o_rd_data), 64'(32'hE000_0000 + 32'(n_pop)));
            n_pop++;
         end
         tick();
      end
      check_eq("stream_pops", 64'(n_pop), 64'd5);
      check_eq("stream_rreqs", 64'(n_rreq), 64'd5);
      check_eq("stream_done_cnt", 64'(n_done), 64'd1);

      // a new read in the second QUIET cycle restarts the quiet window
      push(32'hF000_0000);
      for (int i = 0; i < 12; i++) begin
         if (i == 5) push(32'hF000_0001);
         @(negedge clk);
         if (i == 5) check_eq("restart_rreq", 64'(bus.o_fifo_rreq), 64'h1);
         check_eq("restart_valid", 64'(bus.o_rd_valid), (i == 2 || i == 7) ? 64'h1 : 64'h0);
         if (i == 2) check_eq("restart_d0", 64'(bus.o_rd_data), 64'hF000_0000);
         if (i == 7) check_eq("restart_d1", 64'(bus.o_rd_data), 64'hF000_0001);
         check_eq("restart_done", 64'(bus.o_drain_done), (i == 10) ? 64'h1 : 64'h0);
         tick();
      end

      // reset with a read in flight and a write pending
      bus.i_wr_valid = 4'b0001;
      push(32'h6000_0000);
      @(negedge clk);
      check_eq("inflight_rreq", 64'(bus.o_fifo_rreq), 64'h1);
      check_eq("inflight_grant", 64'(bus.o_wr_ready), 64'h1);
      tick();
      @(negedge clk);
      check_eq("pre_rst_wreq", 64'(bus.o_fifo_wreq), 64'h1);
      reset_n = 1'b0;
      #1;
      check_all_zero("midrst");
      tick();
      tick();
      bus.i_wr_valid = '0;
      reset_n        = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_eq("late_valid", 64'(bus.o_rd_valid), 64'h0);
         check_eq("late_data", 64'(bus.o_rd_data), 64'h0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
